// File: rtl/instr_fetch_stage.sv
// Fetch stage and IF/ID register feeding the control unit.
// Handles stall, branch redirect with flush, and HALT.
module instr_fetch_stage #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        OpCode,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              valid,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL,
    HALT
  } state_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

  state_t            state;
  if_id_t            if_id;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect;
  logic              is_halt;

  assign pc_inc   = pc + ADDR_W'(4);
  assign redirect = branch_target & ~ADDR_W'(3);
  assign is_halt  = imem_rdata[31:26] == HALT_OP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      if_id   <= '0;
      imem_en <= 1'b0;
      halted  <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state   <= RUN;
          imem_en <= 1'b1;
        end
        RUN: begin
          if (branch_taken) begin
            pc          <= redirect;
            if_id.instr <= '0;
            if_id.valid <= 1'b0;
          end else if (stall) begin
            state <= STALL;
          end else begin
            if_id.instr    <= imem_rdata;
            if_id.pc_plus4 <= pc_inc;
            if_id.valid    <= 1'b1;
            pc             <= pc_inc;
            if (is_halt) begin
              state   <= HALT;
              imem_en <= 1'b0;
              halted  <= 1'b1;
            end
          end
        end
        STALL: begin
          if (branch_taken) begin
            pc          <= redirect;
            if_id.instr <= '0;
            if_id.valid <= 1'b0;
            state       <= RUN;
          end else if (!stall) begin
            state <= RUN;
          end
        end
        HALT: begin
          // HALT word is shown for one cycle, then a bubble forever
          if_id.instr <= '0;
          if_id.valid <= 1'b0;
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign imem_addr = pc;
  assign instr     = if_id.instr;
  assign OpCode    = if_id.instr[31:26];
  assign pc_plus4  = if_id.pc_plus4;
  assign valid     = if_id.valid;

endmodule
